// File: rtl/seg_reader_pkg.sv
// Shared constants for the seven-segment glyph reader: glyph geometry, sample
// points, segment patterns (bit order gfedcba) and the FSM state type.
package seg_reader_pkg;

  localparam logic [9:0] GLYPH_W = 10'd80;
  localparam logic [9:0] GLYPH_H = 10'd140;

  localparam int NUM_SEG = 7;
  localparam int NUM_PTS = 9;

  localparam logic [9:0] SEG_A_X = 10'd40, SEG_A_Y = 10'd10;
  localparam logic [9:0] SEG_B_X = 10'd70, SEG_B_Y = 10'd40;
  localparam logic [9:0] SEG_C_X = 10'd70, SEG_C_Y = 10'd100;
  localparam logic [9:0] SEG_D_X = 10'd40, SEG_D_Y = 10'd130;
  localparam logic [9:0] SEG_E_X = 10'd10, SEG_E_Y = 10'd100;
  localparam logic [9:0] SEG_F_X = 10'd10, SEG_F_Y = 10'd40;
  localparam logic [9:0] SEG_G_X = 10'd40, SEG_G_Y = 10'd70;
  localparam logic [9:0] HOLE_U_X = 10'd40, HOLE_U_Y = 10'd40;
  localparam logic [9:0] HOLE_L_X = 10'd40, HOLE_L_Y = 10'd100;

  // Index 0..6 = segments a..g, 7/8 = upper/lower hole.
  localparam logic [NUM_PTS-1:0][9:0] PT_X = {HOLE_L_X, HOLE_U_X, SEG_G_X, SEG_F_X,
                                              SEG_E_X, SEG_D_X, SEG_C_X, SEG_B_X, SEG_A_X};
  localparam logic [NUM_PTS-1:0][9:0] PT_Y = {HOLE_L_Y, HOLE_U_Y, SEG_G_Y, SEG_F_Y,
                                              SEG_E_Y, SEG_D_Y, SEG_C_Y, SEG_B_Y, SEG_A_Y};

  localparam logic [3:0] CODE_FAIL = 4'd10;
  localparam logic [3:0] CODE_NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE} state_e;

  localparam logic [6:0] PAT_0    = 7'b0111111;
  localparam logic [6:0] PAT_1    = 7'b0000110;
  localparam logic [6:0] PAT_2    = 7'b1011011;
  localparam logic [6:0] PAT_3    = 7'b1001111;
  localparam logic [6:0] PAT_4    = 7'b1100110;
  localparam logic [6:0] PAT_5    = 7'b1101101;
  localparam logic [6:0] PAT_6    = 7'b1111101;
  localparam logic [6:0] PAT_7    = 7'b0000111;
  localparam logic [6:0] PAT_8    = 7'b1111111;
  localparam logic [6:0] PAT_9    = 7'b1101111;
  localparam logic [6:0] PAT_FAIL = 7'b1110001;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to glyph-code lookup; unknown patterns or a lit
// hole yield CODE_NONE with err_o set.
module seg_pattern_decode
  import seg_reader_pkg::*;
(
  input  logic [NUM_SEG-1:0] pattern_i,
  input  logic               hole_i,
  output logic [3:0]         code_o,
  output logic               err_o
);

  // The SUCCESS glyph shares the 5 pattern, so code 11 is unreachable.
  always_comb begin
    code_o = CODE_NONE;
    err_o  = 1'b1;
    if (!hole_i) begin
      err_o = 1'b0;
      case (pattern_i)
        PAT_0:    code_o = 4'd0;
        PAT_1:    code_o = 4'd1;
        PAT_2:    code_o = 4'd2;
        PAT_3:    code_o = 4'd3;
        PAT_4:    code_o = 4'd4;
        PAT_5:    code_o = 4'd5;
        PAT_6:    code_o = 4'd6;
        PAT_7:    code_o = 4'd7;
        PAT_8:    code_o = 4'd8;
        PAT_9:    code_o = 4'd9;
        PAT_FAIL: code_o = CODE_FAIL;
        default: begin
          code_o = CODE_NONE;
          err_o  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a seven-segment glyph out of a pixel raster once per frame and reports
// its code plus a stability flag. SEG_READER_MAJORITY_EN selects 3-pixel majority sampling.
module seven_segment_reader
  import seg_reader_pkg::*;
#(
  parameter logic [9:0] X0            = 10'd0,
  parameter logic [9:0] Y0            = 10'd0,
  parameter logic [3:0] STABLE_FRAMES = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       de,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       pixel_in,
  output logic [3:0] number,
  output logic       number_valid,
  output logic       error,
  output logic       stable
);

  state_e               state_q;
  logic [NUM_PTS-1:0]   bits_q;
  logic [3:0]           number_q, cnt_q, cnt_d;
  logic                 error_q, valid_q, stable_q;
  logic [9:0]           dx, dy;
  logic                 in_range, bottom;
  logic [NUM_PTS-1:0]   hit;
  logic [3:0]           dec_code;
  logic                 dec_err;
`ifdef SEG_READER_MAJORITY_EN
  logic [NUM_PTS-1:0][1:0] win_q;
`endif

  assign dx       = sx - X0;
  assign dy       = sy - Y0;
  // Guarding on sx/sy before the subtraction keeps wrapped offsets from aliasing.
  assign in_range = (sx >= X0) && (sy >= Y0) && (dx < GLYPH_W) && (dy < GLYPH_H);
  assign bottom   = ({1'b0, sy} >= ({1'b0, Y0} + {1'b0, GLYPH_H}));

  for (genvar p = 0; p < NUM_PTS; p++) begin : g_pt
`ifdef SEG_READER_MAJORITY_EN
    assign hit[p] = in_range && (dy == PT_Y[p]) &&
                    ((dx == PT_X[p] - 10'd1) || (dx == PT_X[p]) || (dx == PT_X[p] + 10'd1));
`else
    assign hit[p] = in_range && (dy == PT_Y[p]) && (dx == PT_X[p]);
`endif
  end

  seg_pattern_decode u_dec (
    .pattern_i (bits_q[NUM_SEG-1:0]),
    .hole_i    (|bits_q[NUM_PTS-1:NUM_SEG]),
    .code_o    (dec_code),
    .err_o     (dec_err)
  );

  always_comb begin
    cnt_d = 4'd0;
    if (!dec_err) begin
      if (!error_q && (dec_code == number_q))
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bits_q   <= '0;
      number_q <= CODE_NONE;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= 4'd0;
      stable_q <= 1'b0;
`ifdef SEG_READER_MAJORITY_EN
      win_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (state_q == S_DECIDE) begin
        number_q <= dec_code;
        error_q  <= dec_err;
        valid_q  <= 1'b1;
        cnt_q    <= cnt_d;
        stable_q <= (cnt_d >= STABLE_FRAMES);
      end
      if ((state_q == S_SCAN) && frame_start) begin
        number_q <= CODE_NONE;
        error_q  <= 1'b1;
        valid_q  <= 1'b1;
        cnt_q    <= 4'd0;
        stable_q <= (STABLE_FRAMES == 4'd0);
      end
      // Any frame_start lands in SCAN with fresh bits, whatever the current state.
      if (frame_start) begin
        state_q <= S_SCAN;
        bits_q  <= '0;
`ifdef SEG_READER_MAJORITY_EN
        win_q   <= '0;
`endif
      end else begin
        case (state_q)
          S_SCAN: begin
            if (de) begin
              if (bottom) state_q <= S_DECIDE;
              for (int p = 0; p < NUM_PTS; p++) begin
                if (hit[p]) begin
`ifdef SEG_READER_MAJORITY_EN
                  if (pixel_in) begin
                    win_q[p] <= win_q[p] + 2'd1;
                    if (win_q[p] != 2'd0) bits_q[p] <= 1'b1;
                  end
`else
                  bits_q[p] <= pixel_in;
`endif
                end
              end
            end
          end
          S_DECIDE: state_q <= S_IDLE;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign error        = error_q;
  assign stable       = stable_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader: renders sparse glyph frames and
// compares each number_valid pulse against a scoreboard of expected decodes.
module tb_seven_segment_reader;

  localparam int X0 = 100;
  localparam int Y0 = 50;

  localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011,
                         G3 = 7'b1001111, G4 = 7'b1100110, G7 = 7'b0000111,
                         G8 = 7'b1111111, G9 = 7'b1101111, GSUCC = 7'b1101101,
                         GFAIL = 7'b1110001;

  logic       clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, de = 1'b0, pixel_in = 1'b0;
  logic [9:0] sx = '0, sy = '0;
  logic [3:0] number;
  logic       number_valid, error, stable;

  typedef struct packed {logic [3:0] num; logic err; logic stb;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int checks = 0, failures = 0, n_valid = 0;
  logic prev_valid = 1'b0;
  logic [3:0] m_code = 4'hF;
  logic m_err = 1'b0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  seven_segment_reader #(.X0(10'd100), .Y0(10'd50), .STABLE_FRAMES(4'd3)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .de(de), .sx(sx), .sy(sy),
    .pixel_in(pixel_in), .number(number), .number_valid(number_valid), .error(error),
    .stable(stable)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && number_valid) begin
      n_valid++;
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL valid_width got two-cycle pulse, required one cycle");
      end
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got number=%0d error=%0b, required no pulse", number, error);
      end else begin
        mon_e = sb.pop_front();
        checks += 3;
        if (number !== mon_e.num) begin
          failures++;
          $display("FAIL sb_number got %0d required %0d", number, mon_e.num);
        end
        if (error !== mon_e.err) begin
          failures++;
          $display("FAIL sb_error got %0b required %0b", error, mon_e.err);
        end
        if (stable !== mon_e.stb) begin
          failures++;
          $display("FAIL sb_stable got %0b required %0b", stable, mon_e.stb);
        end
      end
    end
    prev_valid = rst_n && number_valid;
  end

  function automatic logic glyph_px(input logic [6:0] s, input int x, input int y);
    if (x < 0 || y < 0) return 1'b1;
    return (s[0] && y >= 5   && y <= 15  && x >= 15 && x <= 65) ||
           (s[1] && x >= 65  && x <= 75  && y >= 15 && y <= 65) ||
           (s[2] && x >= 65  && x <= 75  && y >= 75 && y <= 125) ||
           (s[3] && y >= 125 && y <= 135 && x >= 15 && x <= 65) ||
           (s[4] && x >= 5   && x <= 15  && y >= 75 && y <= 125) ||
           (s[5] && x >= 5   && x <= 15  && y >= 15 && y <= 65) ||
           (s[6] && y >= 65  && y <= 75  && x >= 15 && x <= 65);
  endfunction

  task automatic expect_decode(input logic [3:0] code, input logic err);
    exp_t e;
    if (err) m_cnt = 0;
    else if (!m_err && code == m_code) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
    else m_cnt = 1;
    m_code = err ? 4'hF : code;
    m_err  = err;
    e.num = m_code;
    e.err = err;
    e.stb = (m_cnt >= 3);
    sb.push_back(e);
  endtask

  task automatic drv(input logic fs, input logic d, input int x, input int y, input logic p);
    frame_start = fs;
    de          = d;
    sx          = 10'(x);
    sy          = 10'(y);
    pixel_in    = p;
    @(posedge clk);
    #1;
  endtask

  // Sparse raster: only the rows holding sample points, plus one row above the glyph.
  task automatic drive_rows(input logic [6:0] s, input int fx, input int fy, input int fw,
                            input logic fv, input int lo, input int hi);
    int rows[6] = '{-1, 10, 40, 70, 100, 130};
    logic p;
    for (int i = 0; i < 6; i++) begin
      if (rows[i] >= lo && rows[i] < hi) begin
        for (int x = -2; x <= 82; x++) begin
          p = glyph_px(s, x, rows[i]);
          if (rows[i] == fy && x >= fx - fw && x <= fx + fw) p = fv;
          drv(1'b0, 1'b1, X0 + x, Y0 + rows[i], p);
        end
        drv(1'b0, 1'b0, 0, 0, 1'b0);
      end
    end
  endtask

  task automatic drive_frame(input logic [6:0] s, input int fx, input int fy, input int fw,
                             input logic fv);
    drv(1'b1, 1'b1, 0, 0, 1'b0);
    drive_rows(s, fx, fy, fw, fv, -10, 200);
    drv(1'b0, 1'b1, 0, Y0 + 140, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      drv(1'b0, 1'b0, 0, 0, 1'b0);
      n++;
    end
    drv(1'b0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) drv(1'b0, 1'b0, 0, 0, 1'b0);
    checks += 4;
    if (number !== 4'hF) begin failures++; $display("FAIL reset_number got %0h required f", number); end
    if (number_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b required 0", number_valid); end
    if (error !== 1'b0) begin failures++; $display("FAIL reset_error got %0b required 0", error); end
    if (stable !== 1'b0) begin failures++; $display("FAIL reset_stable got %0b required 0", stable); end
    rst_n = 1'b1;
    repeat (2) drv(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_digit3();
    expect_decode(4'd3, 1'b0);
    drive_frame(G3, -100, -100, 0, 1'b0);
    checks++;
    if (number_valid !== 1'b0) begin failures++; $display("FAIL lat_decide got valid=%0b required 0", number_valid); end
    drv(1'b0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (number_valid !== 1'b1) begin failures++; $display("FAIL lat_pulse got valid=%0b required 1", number_valid); end
    drv(1'b0, 1'b0, 0, 0, 1'b0);
    checks += 2;
    if (number_valid !== 1'b0) begin failures++; $display("FAIL lat_after got valid=%0b required 0", number_valid); end
    if (number !== 4'd3) begin failures++; $display("FAIL hold_number got %0d required 3", number); end
    wait_drain("digit3");
  endtask

  task automatic test_stable();
    for (int i = 0; i < 3; i++) begin
      expect_decode(4'd8, 1'b0);
      drive_frame(G8, -100, -100, 0, 1'b0);
      wait_drain("stable8");
    end
    checks++;
    if (stable !== 1'b1) begin failures++; $display("FAIL stable_hold got %0b required 1", stable); end
    expect_decode(4'd2, 1'b0);
    drive_frame(G2, -100, -100, 0, 1'b0);
    wait_drain("stable2");
  endtask

  task automatic test_fail_success();
    expect_decode(4'd10, 1'b0);
    drive_frame(GFAIL, -100, -100, 0, 1'b0);
    wait_drain("failglyph");
    expect_decode(4'd5, 1'b0);
    drive_frame(GSUCC, -100, -100, 0, 1'b0);
    wait_drain("success");
  endtask

  task automatic test_hole();
    expect_decode(4'hF, 1'b1);
    drive_frame(G0, 40, 40, 1, 1'b1);
    wait_drain("hole");
  endtask

  task automatic test_abort();
    drv(1'b1, 1'b1, 0, 0, 1'b0);
    drive_rows(G7, -100, -100, 0, 1'b0, -10, 70);
    expect_decode(4'hF, 1'b1);
    drv(1'b1, 1'b1, X0, Y0 + 70, 1'b0);
    checks++;
    if (number_valid !== 1'b1) begin failures++; $display("FAIL abort_pulse got valid=%0b required 1", number_valid); end
    expect_decode(4'd7, 1'b0);
    drive_rows(G7, -100, -100, 0, 1'b0, -10, 200);
    drv(1'b0, 1'b1, 0, Y0 + 140, 1'b0);
    wait_drain("abort");
  endtask

  task automatic test_back_to_back();
    expect_decode(4'd9, 1'b0);
    expect_decode(4'd9, 1'b0);
    drive_frame(G9, -100, -100, 0, 1'b0);
    drive_frame(G9, -100, -100, 0, 1'b0);
    wait_drain("b2b");
  endtask

  task automatic test_reset_midframe();
    int nv;
    drv(1'b1, 1'b1, 0, 0, 1'b0);
    drive_rows(G4, -100, -100, 0, 1'b0, -10, 60);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (number !== 4'hF) begin failures++; $display("FAIL rst_mid_number got %0h required f", number); end
    if (number_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %0b required 0", number_valid); end
    if (error !== 1'b0) begin failures++; $display("FAIL rst_mid_error got %0b required 0", error); end
    if (stable !== 1'b0) begin failures++; $display("FAIL rst_mid_stable got %0b required 0", stable); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_code = 4'hF; m_err = 1'b0; m_cnt = 0;
    nv = n_valid;
    drive_rows(G4, -100, -100, 0, 1'b0, 60, 200);
    drv(1'b0, 1'b1, 0, Y0 + 140, 1'b0);
    repeat (5) drv(1'b0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (n_valid != nv) begin failures++; $display("FAIL partial_frame got %0d pulses required 0", n_valid - nv); end
    expect_decode(4'd4, 1'b0);
    drive_frame(G4, -100, -100, 0, 1'b0);
    wait_drain("post_reset");
  endtask

  task automatic test_window();
    expect_decode(4'd1, 1'b0);
    drive_frame(G1, 69, 100, 0, 1'b0);
    wait_drain("win_adjacent");
`ifdef SEG_READER_MAJORITY_EN
    expect_decode(4'd1, 1'b0);
`else
    expect_decode(4'hF, 1'b1);
`endif
    drive_frame(G1, 70, 100, 0, 1'b0);
    wait_drain("win_center");
  endtask

  initial begin
    test_reset();
    test_digit3();
    test_stable();
    test_fail_success();
    test_hole();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    test_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
